// File: rtl/m_muxnway_arb.sv
`default_nettype none
// ============================================================================
//  Module   : m_muxnway_arb
//  Purpose  : N-channel, WIDTH-bit registered multiplexer with per-channel
//             valid/ready handshake. The source channel is chosen either by
//             an external select (mode 0) or by round-robin arbitration
//             (mode 1). Output is a single registered valid/ready stage with
//             full throughput and no bubble on simultaneous consume/accept.
//  Ports    :
//    i_clk    in   1        clock, rising edge
//    i_rst_n  in   1        asynchronous active-low reset
//    i_mode   in   1        0 = fixed select, 1 = round-robin
//    i_sel    in   SELW     channel passed in fixed mode
//    i_valid  in   N        per-channel valid
//    i_data   in   N*WIDTH  channel k data at [k*WIDTH +: WIDTH]
//    o_ready  out  N        per-channel accept (one-hot or zero)
//    o_valid  out  1        output register holds data
//    o_data   out  WIDTH    registered selected data
//    o_chan   out  SELW     channel index that supplied o_data
//    i_ready  in   1        consumer accepts
//  Revision : 1.0  initial release
// ============================================================================
module m_muxnway_arb #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_mode,
  input  logic [SELW-1:0]    i_sel,
  input  logic [N-1:0]       i_valid,
  input  logic [N*WIDTH-1:0] i_data,
  output logic [N-1:0]       o_ready,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_data,
  output logic [SELW-1:0]    o_chan,
  input  logic               i_ready
);

  // One extra bit so N itself (and ptr+offset sums up to 2N-1) are representable.
  localparam logic [SELW:0]   c_n    = (SELW+1)'(N);
  localparam logic [SELW-1:0] c_last = SELW'(N-1);

  logic [SELW-1:0] r_ptr;
  logic            w_load_en;
  logic [N-1:0]    w_grant;
  logic            w_any;
  logic [SELW-1:0] w_gidx;
  logic [SELW:0]   w_cand;
  logic [WIDTH-1:0] w_data;

  assign w_load_en = ~o_valid | i_ready;

  // Grant selection: fixed select or first valid channel after the pointer.
  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    if (!i_mode) begin
      if (({1'b0, i_sel} < c_n) && i_valid[i_sel]) begin
        w_grant[i_sel] = 1'b1;
        w_any          = 1'b1;
        w_gidx         = i_sel;
      end
    end else begin
      for (int off = 1; off <= N; off++) begin
        w_cand = {1'b0, r_ptr} + (SELW+1)'(off);
        // ptr < N and off <= N, so one subtraction completes the modulo
        if (w_cand >= c_n) w_cand = w_cand - c_n;
        if (!w_any && i_valid[w_cand[SELW-1:0]]) begin
          w_grant[w_cand[SELW-1:0]] = 1'b1;
          w_any                     = 1'b1;
          w_gidx                    = w_cand[SELW-1:0];
        end
      end
    end
  end

  assign w_data = i_data[int'(w_gidx)*WIDTH +: WIDTH];

  // Reset gating keeps o_ready low while reset is asserted even though the
  // empty output register would otherwise advertise load_en.
  assign o_ready = w_grant & {N{w_load_en & i_rst_n}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_chan  <= '0;
      r_ptr   <= c_last;
    end else if (w_load_en) begin
      if (w_any) begin
        o_valid <= 1'b1;
        o_data  <= w_data;
        o_chan  <= w_gidx;
        if (i_mode) r_ptr <= w_gidx;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
